// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 8 data bits LSB first, odd parity, one stop bit.
// Bit timing comes from a cycle counter; every bit is sampled at its centre.
module uart_rx_os #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t        state, state_n;
  logic          sync1, rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic          par, par_n;
  logic [7:0]    data_out_n;
  logic          ready_n, perr_n, ferr_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      sh            <= '0;
      par           <= 1'b0;
      data_out      <= '0;
      data_ready    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      idx           <= idx_n;
      sh            <= sh_n;
      par           <= par_n;
      data_out      <= data_out_n;
      data_ready    <= ready_n;
      parity_error  <= perr_n;
      framing_error <= ferr_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    sh_n       = sh;
    par_n      = par;
    data_out_n = data_out;
    ready_n    = 1'b0;
    perr_n     = 1'b0;
    ferr_n     = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        // Half a bit in: a line that is high again was only a glitch.
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          sh_n[idx] = rx_s;
          if (idx == 3'd7) state_n = PARITY;
          else             idx_n   = idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          par_n   = rx_s;
          state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
            if (par == ~(^sh)) begin
              ready_n    = 1'b1;
              data_out_n = sh;
            end else begin
              perr_n = 1'b1;
            end
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: drives serial frames, predicts each result pulse
// (kind, cycle, data_out) into a queue and matches it when the DUT pulses.
module tb_uart_rx_os;

  localparam int CPB     = 16;
  localparam int K_READY = 0;
  localparam int K_PAR   = 1;
  localparam int K_FRAME = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_ready, parity_error, framing_error, busy;

  uart_rx_os #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .data_out(data_out), .data_ready(data_ready),
    .parity_error(parity_error), .framing_error(framing_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] dout;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    bit         flip;
    bit         stop;
    int         kind;
    logic [7:0] dout;
  } vec_t;

  exp_t sbq[$];
  int   ready_cycs[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   busy_cnt = 0;
  bit   cnt_en = 1'b0;
  vec_t vecs[8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (cnt_en) busy_cnt += int'(busy);

  always @(negedge clk) begin
    int   k, nfl;
    exp_t e;
    nfl = int'(data_ready) + int'(parity_error) + int'(framing_error);
    if (nfl > 1) begin
      checks++;
      errors++;
      $display("FAIL onehot: %0d flags high at cycle %0d, required at most 1", nfl, cyc);
    end else if (nfl == 1) begin
      k = data_ready ? K_READY : (parity_error ? K_PAR : K_FRAME);
      if (data_ready) ready_cycs.push_back(cyc);
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: kind=%0d cycle=%0d data_out=%02h, required no event",
                 k, cyc, data_out);
      end else begin
        e = sbq.pop_front();
        if (k != e.kind || cyc != e.cyc || data_out !== e.dout) begin
          errors++;
          $display("FAIL event: kind=%0d cycle=%0d data_out=%02h, required kind=%0d cycle=%0d data_out=%02h",
                   k, cyc, data_out, e.kind, e.cyc, e.dout);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_wait();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Call at posedge+1. Line falls after edge N, so the stop sample lands on edge N+3+168.
  task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop,
                            input int kind, input logic [7:0] dout, input bit hold_low);
    exp_t e;
    logic par;
    par    = ~(^d) ^ flip;
    e.kind = kind;
    e.dout = dout;
    e.cyc  = cyc + 171;
    sbq.push_back(e);
    rx = 1'b0;
    bit_wait();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      bit_wait();
    end
    rx = par;
    bit_wait();
    rx = stop;
    bit_wait();
    if (!hold_low) rx = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    vecs[0] = '{8'h00, 1'b0, 1'b1, K_READY, 8'h00};
    vecs[1] = '{8'hFF, 1'b0, 1'b1, K_READY, 8'hFF};
    vecs[2] = '{8'h3C, 1'b1, 1'b1, K_PAR,   8'hFF};
    vecs[3] = '{8'h80, 1'b0, 1'b0, K_FRAME, 8'hFF};
    vecs[4] = '{8'h55, 1'b0, 1'b1, K_READY, 8'h55};
    vecs[5] = '{8'h6E, 1'b1, 1'b1, K_PAR,   8'h55};
    vecs[6] = '{8'hC3, 1'b0, 1'b1, K_READY, 8'hC3};
    vecs[7] = '{8'h12, 1'b1, 1'b0, K_FRAME, 8'hC3};

    // Asynchronous reset before any clock edge, then a quiet line.
    #2 reset = 1'b1;
    #1;
    chk("reset_data_out", 32'(data_out), 32'h00);
    chk("reset_data_ready", 32'(data_ready), 32'h0);
    chk("reset_parity_error", 32'(parity_error), 32'h0);
    chk("reset_framing_error", 32'(framing_error), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    #20 reset = 1'b0;
    busy_cnt = 0;
    cnt_en = 1'b1;
    idle(100);
    cnt_en = 1'b0;
    chk("idle_busy_cycles", 32'(busy_cnt), 32'd0);

    // Good byte.
    align();
    send_frame(8'hA5, 1'b0, 1'b1, K_READY, 8'hA5, 1'b0);
    idle(5);
    chk("a5_data_out", 32'(data_out), 32'hA5);
    chk("a5_busy_after", 32'(busy), 32'h0);

    // Short start glitch: busy for half a bit, nothing else.
    align();
    busy_cnt = 0;
    cnt_en = 1'b1;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(30);
    cnt_en = 1'b0;
    chk("glitch_busy_cycles", 32'(busy_cnt), 32'd8);
    chk("glitch_data_out", 32'(data_out), 32'hA5);

    // Wrong parity keeps the previous byte.
    align();
    send_frame(8'h01, 1'b1, 1'b1, K_PAR, 8'hA5, 1'b0);
    idle(20);
    chk("perr_data_out", 32'(data_out), 32'hA5);

    foreach (vecs[i]) begin
      align();
      send_frame(vecs[i].d, vecs[i].flip, vecs[i].stop, vecs[i].kind, vecs[i].dout, 1'b0);
      idle(20);
      chk($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(vecs[i].dout));
    end

    // Framing error followed by a long break.
    align();
    send_frame(8'h3C, 1'b0, 1'b0, K_FRAME, 8'hC3, 1'b1);
    idle(200);
    chk("break_busy_held", 32'(busy), 32'h1);
    rx = 1'b1;
    idle(6);
    chk("break_busy_released", 32'(busy), 32'h0);
    chk("break_queue_empty", 32'(sbq.size()), 32'd0);

    // Reset during data bit 3 of an abandoned frame.
    align();
    rx = 1'b0;
    bit_wait();
    rx = 1'b0; bit_wait();
    rx = 1'b1; bit_wait();
    rx = 1'b0; bit_wait();
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midframe_reset_data_out", 32'(data_out), 32'h00);
    chk("midframe_reset_busy", 32'(busy), 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(10);
    chk("post_reset_busy", 32'(busy), 32'h0);

    // Back-to-back frames with no idle gap.
    ready_cycs.delete();
    align();
    send_frame(8'h3C, 1'b0, 1'b1, K_READY, 8'h3C, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1, K_READY, 8'hC3, 1'b0);
    idle(20);
    chk("b2b_ready_count", 32'(ready_cycs.size()), 32'd2);
    gap = (ready_cycs.size() >= 2) ? ready_cycs[1] - ready_cycs[0] : 0;
    chk("b2b_ready_gap", 32'(gap), 32'd176);
    chk("b2b_data_out", 32'(data_out), 32'hC3);

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
